cart_arbiter: RTL and testbench

CART_ARBITER -- requirements
Module: cart_arbiter

---
 rtl/cart_arbiter_if.sv | 35 +++
 rtl/cart_arbiter.sv | 144 ++++++++++++++
 tb/tb_cart_arbiter.sv | 365 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cart_arbiter_if.sv
// Cartridge bus bundle: CPU and DMA request ports plus the mapper access port.
// The arbiter takes the slave view; the environment (CPU, DMA, mapper) takes the master view.
interface cart_arbiter_if;
    logic [15:0] cpu_address;
    logic [7:0]  cpu_indata;
    logic        cpu_load;
    logic        cpu_store;
    logic [7:0]  cpu_outdata;
    logic        cpu_ready;

    logic [15:0] dma_address;
    logic        dma_load;
    logic [7:0]  dma_outdata;
    logic        dma_ready;

    logic [15:0] address;
    logic [7:0]  indata;
    logic [7:0]  outdata;
    logic        load;
    logic        store;

    modport slave (
        input  cpu_address, cpu_indata, cpu_load, cpu_store,
        input  dma_address, dma_load, outdata,
        output cpu_outdata, cpu_ready, dma_outdata, dma_ready,
        output address, indata, load, store
    );

    modport master (
        output cpu_address, cpu_indata, cpu_load, cpu_store,
        output dma_address, dma_load, outdata,
        input  cpu_outdata, cpu_ready, dma_outdata, dma_ready,
        input  address, indata, load, store
    );
endinterface

// File: rtl/cart_arbiter.sv
// Purpose: shares the cartridge mapper between CPU and DMA, one access at a time.
// Latency: grant in IDLE, then LATENCY read cycles (or 1 write cycle), then a DONE cycle with ready.
// Backpressure: requests are level-held until ready; DMA burst is capped while a CPU request waits.
module cart_arbiter #(
    parameter int LATENCY   = 2,
    parameter int DMA_BURST = 4
) (
    input  logic           clockgb,
    input  logic           resetn,
    cart_arbiter_if.slave  bus
);

    typedef enum logic [2:0] {IDLE, CPU_RD, CPU_WR, DMA_RD, DONE} state_t;

    localparam logic [2:0] LAT_LAST  = 3'(LATENCY - 1);
    localparam logic [3:0] BURST_MAX = 4'(DMA_BURST);

    state_t      state, state_n;
    logic [2:0]  lat_cnt, lat_n;
    logic [3:0]  burst_cnt, burst_n;
    logic [15:0] addr_q, addr_n;
    logic [7:0]  wdat_q, wdat_n;
    logic [7:0]  cpu_rdat_q, cpu_rdat_n;
    logic [7:0]  dma_rdat_q, dma_rdat_n;
    logic        load_q, load_n;
    logic        store_q, store_n;
    logic        cpu_rdy_q, cpu_rdy_n;
    logic        dma_rdy_q, dma_rdy_n;

    logic cpu_req;
    logic dma_win;

    assign cpu_req = bus.cpu_load | bus.cpu_store;
    // DMA keeps priority until it has used its burst allowance against a waiting CPU.
    assign dma_win = bus.dma_load & (~cpu_req | (burst_cnt < BURST_MAX));

    always_ff @(posedge clockgb or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            lat_cnt    <= '0;
            burst_cnt  <= '0;
            addr_q     <= '0;
            wdat_q     <= '0;
            cpu_rdat_q <= '0;
            dma_rdat_q <= '0;
            load_q     <= 1'b0;
            store_q    <= 1'b0;
            cpu_rdy_q  <= 1'b0;
            dma_rdy_q  <= 1'b0;
        end else begin
            state      <= state_n;
            lat_cnt    <= lat_n;
            burst_cnt  <= burst_n;
            addr_q     <= addr_n;
            wdat_q     <= wdat_n;
            cpu_rdat_q <= cpu_rdat_n;
            dma_rdat_q <= dma_rdat_n;
            load_q     <= load_n;
            store_q    <= store_n;
            cpu_rdy_q  <= cpu_rdy_n;
            dma_rdy_q  <= dma_rdy_n;
        end
    end

    // Mapper-side outputs are registered: values computed here appear on the next cycle.
    always_comb begin
        state_n    = state;
        lat_n      = lat_cnt;
        burst_n    = burst_cnt;
        addr_n     = '0;
        wdat_n     = '0;
        cpu_rdat_n = cpu_rdat_q;
        dma_rdat_n = dma_rdat_q;
        load_n     = 1'b0;
        store_n    = 1'b0;
        cpu_rdy_n  = 1'b0;
        dma_rdy_n  = 1'b0;

        case (state)
            IDLE: begin
                if (!cpu_req) begin
                    burst_n = '0;
                end
                if (dma_win) begin
                    state_n = DMA_RD;
                    addr_n  = bus.dma_address;
                    load_n  = 1'b1;
                    lat_n   = LAT_LAST;
                    if (cpu_req) begin
                        burst_n = burst_cnt + 4'd1;
                    end
                end else if (cpu_req) begin
                    burst_n = '0;
                    addr_n  = bus.cpu_address;
                    if (bus.cpu_store) begin
                        state_n = CPU_WR;
                        wdat_n  = bus.cpu_indata;
                        store_n = 1'b1;
                    end else begin
                        state_n = CPU_RD;
                        load_n  = 1'b1;
                        lat_n   = LAT_LAST;
                    end
                end
            end
            CPU_RD, DMA_RD: begin
                if (lat_cnt == 3'd0) begin
                    state_n = DONE;
                    if (state == CPU_RD) begin
                        cpu_rdat_n = bus.outdata;
                        cpu_rdy_n  = 1'b1;
                    end else begin
                        dma_rdat_n = bus.outdata;
                        dma_rdy_n  = 1'b1;
                    end
                end else begin
                    addr_n = addr_q;
                    load_n = 1'b1;
                    lat_n  = lat_cnt - 3'd1;
                end
            end
            CPU_WR: begin
                state_n   = DONE;
                cpu_rdy_n = 1'b1;
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign bus.address     = addr_q;
    assign bus.indata      = wdat_q;
    assign bus.load        = load_q;
    assign bus.store       = store_q;
    assign bus.cpu_outdata = cpu_rdat_q;
    assign bus.dma_outdata = dma_rdat_q;
    assign bus.cpu_ready   = cpu_rdy_q;
    assign bus.dma_ready   = dma_rdy_q;

endmodule

// File: tb/tb_cart_arbiter.sv
// Bench for cart_arbiter: scoreboard of expected mapper accesses checked against a bus monitor.
module tb_cart_arbiter;

    localparam int LAT   = 2;
    localparam int BURST = 4;

    typedef struct packed {
        logic        is_dma;
        logic        is_wr;
        logic        clean;
        logic [15:0] addr;
        logic [7:0]  data;
        logic [7:0]  other;
        logic [3:0]  cycles;
    } acc_t;

    logic clockgb;
    logic resetn;
    cart_arbiter_if bus ();

    cart_arbiter #(.LATENCY(LAT), .DMA_BURST(BURST)) dut (
        .clockgb (clockgb),
        .resetn  (resetn),
        .bus     (bus)
    );

    function automatic logic [7:0] map_f(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h92;
    endfunction

    assign bus.outdata = map_f(bus.address);

    initial begin
        clockgb = 1'b0;
        forever #5 clockgb = ~clockgb;
    end

    int   cyc = 0;
    always @(posedge clockgb) cyc <= cyc + 1;

    acc_t exp_q[$];
    acc_t obs_q[$];
    int   obs_cyc_q[$];
    acc_t cur;
    bit   in_acc;
    int   both_rdy;
    bit   dma_hold;
    logic [7:0] last_cpu_rd, last_dma_rd;
    int   n_cmp, n_bad;

    // Bus monitor: folds each mapper access and the ready that closes it into one record.
    always @(negedge clockgb) begin
        if (!resetn) begin
            in_acc = 1'b0;
        end else begin
            if (bus.cpu_ready && bus.dma_ready) both_rdy++;
            if (bus.load || bus.store) begin
                if (!in_acc) begin
                    cur       = '0;
                    cur.clean = 1'b1;
                    cur.addr  = bus.address;
                    cur.is_wr = bus.store;
                    if (bus.store) cur.data = bus.indata;
                    in_acc = 1'b1;
                end
                if ((bus.load && bus.store) || bus.address !== cur.addr || bus.store !== cur.is_wr ||
                    (bus.store && bus.indata !== cur.data))
                    cur.clean = 1'b0;
                cur.cycles = cur.cycles + 4'd1;
            end
            if (bus.cpu_ready || bus.dma_ready) begin
                if (!in_acc || bus.address !== 16'h0 || bus.load || bus.store) cur.clean = 1'b0;
                cur.is_dma = bus.dma_ready;
                if (!cur.is_wr) cur.data = bus.dma_ready ? bus.dma_outdata : bus.cpu_outdata;
                cur.other = bus.dma_ready ? bus.cpu_outdata : bus.dma_outdata;
                obs_q.push_back(cur);
                obs_cyc_q.push_back(cyc);
                in_acc = 1'b0;
            end
        end
    end

    function automatic logic [43:0] outs();
        return {bus.cpu_outdata, bus.dma_outdata, bus.cpu_ready, bus.dma_ready,
                bus.address, bus.indata, bus.load, bus.store};
    endfunction

    task automatic push_exp(input bit dma, input bit wr, input logic [15:0] a, input logic [7:0] d);
        acc_t e;
        e        = '0;
        e.is_dma = dma;
        e.is_wr  = wr;
        e.clean  = 1'b1;
        e.addr   = a;
        e.data   = d;
        e.cycles = wr ? 4'd1 : 4'(LAT);
        exp_q.push_back(e);
    endtask

    task automatic cpu_issue(input logic [15:0] a, input logic [7:0] d, input bit st);
        bus.cpu_address = a;
        bus.cpu_indata  = d;
        bus.cpu_load    = !st;
        bus.cpu_store   = st;
        push_exp(1'b0, st, a, st ? d : map_f(a));
    endtask

    task automatic dma_issue(input logic [15:0] a);
        bus.dma_address = a;
        bus.dma_load    = 1'b1;
    endtask

    task automatic wait_obs(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clockgb); #1;
            if (obs_q.size() >= n) dma_hold = 1'b0;
            if (bus.cpu_ready) begin
                bus.cpu_load  = 1'b0;
                bus.cpu_store = 1'b0;
            end
            if (bus.dma_ready && !dma_hold) bus.dma_load = 1'b0;
            if (obs_q.size() >= n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Pops one expected/observed pair; the untouched register must still hold its last read.
    task automatic pop_pair(output acc_t e, output acc_t o, output int oc);
        e = exp_q.size() > 0 ? exp_q.pop_front() : '0;
        if (obs_q.size() > 0) begin
            o  = obs_q.pop_front();
            oc = obs_cyc_q.pop_front();
        end else begin
            o  = '1;
            oc = -1;
        end
        e.other = e.is_dma ? last_cpu_rd : last_dma_rd;
        if (!e.is_wr) begin
            if (e.is_dma) last_dma_rd = e.data;
            else          last_cpu_rd = e.data;
        end
    endtask

    task automatic test_reset();
        resetn = 1'b1;
        #2 resetn = 1'b0;
        last_cpu_rd = 8'h0;
        last_dma_rd = 8'h0;
        repeat (2) @(negedge clockgb);
        n_cmp++;
        if (outs() !== 44'h0) begin n_bad++; $display("FAIL reset_outputs got=%h want=0", outs()); end
        #1 resetn = 1'b1;
        repeat (3) @(negedge clockgb);
        n_cmp++;
        if (outs() !== 44'h0) begin n_bad++; $display("FAIL idle_outputs got=%h want=0", outs()); end
        n_cmp++;
        if (obs_q.size() != 0) begin n_bad++; $display("FAIL idle_ready got=%0d want=0", obs_q.size()); end
    endtask

    task automatic test_single(input string name, input logic [15:0] a, input logic [7:0] d,
                               input bit ld, input bit st, input logic [7:0] want_d, input int span);
        acc_t e, o; int oc, t0; bit ok;
        @(negedge clockgb); #1;
        bus.cpu_address = a;
        bus.cpu_indata  = d;
        bus.cpu_load    = ld;
        bus.cpu_store   = st;
        push_exp(1'b0, st, a, want_d);
        t0 = cyc;
        wait_obs(1, 20, ok);
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL %s_timeout got=no_ready want=ready", name); end
        pop_pair(e, o, oc);
        n_cmp++;
        if (o !== e) begin n_bad++; $display("FAIL %s_access got=%h want=%h", name, o, e); end
        n_cmp++;
        if (oc - t0 + 1 != span) begin n_bad++; $display("FAIL %s_latency got=%0d want=%0d", name, oc - t0 + 1, span); end
    endtask

    task automatic test_cpu_read();
        test_single("cpu_read", 16'h0150, 8'h00, 1'b1, 1'b0, 8'hC3, LAT + 2);
    endtask

    task automatic test_cpu_write();
        test_single("cpu_write", 16'h2000, 8'h05, 1'b0, 1'b1, 8'h05, 3);
    endtask

    task automatic test_both_strobes();
        test_single("both_strobes", 16'h4000, 8'h5A, 1'b1, 1'b1, 8'h5A, 3);
    endtask

    task automatic test_same_cycle();
        acc_t e, o; int oc, prev; bit ok;
        @(negedge clockgb); #1;
        dma_issue(16'h8001);
        push_exp(1'b1, 1'b0, 16'h8001, map_f(16'h8001));
        cpu_issue(16'h1234, 8'h00, 1'b0);
        wait_obs(2, 30, ok);
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL same_cycle_timeout got=%0d want=2", obs_q.size()); end
        prev = 0;
        for (int k = 0; k < 2; k++) begin
            pop_pair(e, o, oc);
            n_cmp++;
            if (o !== e) begin n_bad++; $display("FAIL same_cycle_acc%0d got=%h want=%h", k, o, e); end
            if (k == 1) begin
                n_cmp++;
                if (oc - prev != LAT + 2) begin n_bad++; $display("FAIL same_cycle_gap got=%0d want=%0d", oc - prev, LAT + 2); end
            end
            prev = oc;
        end
    endtask

    task automatic test_burst();
        acc_t e, o; int oc, prev; bit ok;
        @(negedge clockgb); #1;
        dma_hold = 1'b1;
        dma_issue(16'h9000);
        for (int k = 0; k < BURST; k++) push_exp(1'b1, 1'b0, 16'h9000, map_f(16'h9000));
        cpu_issue(16'h0333, 8'h00, 1'b0);
        push_exp(1'b1, 1'b0, 16'h9000, map_f(16'h9000));
        wait_obs(BURST + 2, 80, ok);
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL burst_timeout got=%0d want=%0d", obs_q.size(), BURST + 2); end
        prev = 0;
        for (int k = 0; k < BURST + 2; k++) begin
            pop_pair(e, o, oc);
            n_cmp++;
            if (o !== e) begin n_bad++; $display("FAIL burst_acc%0d got=%h want=%h", k, o, e); end
            if (k > 0) begin
                n_cmp++;
                if (oc - prev != LAT + 2) begin n_bad++; $display("FAIL burst_gap%0d got=%0d want=%0d", k, oc - prev, LAT + 2); end
            end
            prev = oc;
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] ad [4];
        logic [7:0]  dd [4];
        bit          st [4];
        acc_t e, o; int oc, prev, idx;
        ad[0] = 16'h2100; dd[0] = 8'h11; st[0] = 1'b1;
        ad[1] = 16'h0200; dd[1] = 8'h00; st[1] = 1'b0;
        ad[2] = 16'h3000; dd[2] = 8'h22; st[2] = 1'b1;
        ad[3] = 16'h7FFF; dd[3] = 8'h00; st[3] = 1'b0;
        @(negedge clockgb); #1;
        cpu_issue(ad[0], dd[0], st[0]);
        idx = 1;
        for (int c = 0; c < 60 && obs_q.size() < 4; c++) begin
            @(negedge clockgb); #1;
            if (bus.cpu_ready) begin
                if (idx < 4) begin
                    cpu_issue(ad[idx], dd[idx], st[idx]);
                    idx++;
                end else begin
                    bus.cpu_load  = 1'b0;
                    bus.cpu_store = 1'b0;
                end
            end
        end
        n_cmp++;
        if (obs_q.size() != 4) begin n_bad++; $display("FAIL b2b_timeout got=%0d want=4", obs_q.size()); end
        prev = 0;
        for (int k = 0; k < 4; k++) begin
            pop_pair(e, o, oc);
            n_cmp++;
            if (o !== e) begin n_bad++; $display("FAIL b2b_acc%0d got=%h want=%h", k, o, e); end
            if (k > 0) begin
                n_cmp++;
                if (oc - prev != (st[k] ? 3 : LAT + 2))
                    begin n_bad++; $display("FAIL b2b_gap%0d got=%0d want=%0d", k, oc - prev, st[k] ? 3 : LAT + 2); end
            end
            prev = oc;
        end
        bus.cpu_load  = 1'b0;
        bus.cpu_store = 1'b0;
    endtask

    task automatic test_drop_mid();
        acc_t e, o; int oc; bit ok;
        @(negedge clockgb); #1;
        cpu_issue(16'h0456, 8'h00, 1'b0);
        @(negedge clockgb); #1;
        bus.cpu_load    = 1'b0;
        bus.cpu_address = 16'hFFFF;
        wait_obs(1, 20, ok);
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL drop_mid_timeout got=no_ready want=ready"); end
        pop_pair(e, o, oc);
        n_cmp++;
        if (o !== e) begin n_bad++; $display("FAIL drop_mid_acc got=%h want=%h", o, e); end
    endtask

    task automatic test_reset_mid();
        acc_t e, o; int oc, t0; bit ok;
        @(negedge clockgb); #1;
        dma_hold = 1'b1;
        dma_issue(16'h8800);
        @(negedge clockgb); #1;
        n_cmp++;
        if (bus.load !== 1'b1) begin n_bad++; $display("FAIL reset_mid_pre got=%b want=1", bus.load); end
        resetn = 1'b0;
        #1;
        n_cmp++;
        if (outs() !== 44'h0) begin n_bad++; $display("FAIL reset_mid_outputs got=%h want=0", outs()); end
        last_cpu_rd = 8'h0;
        last_dma_rd = 8'h0;
        repeat (2) @(negedge clockgb);
        #1;
        n_cmp++;
        if (obs_q.size() != 0) begin n_bad++; $display("FAIL reset_mid_ready got=%0d want=0", obs_q.size()); end
        resetn = 1'b1;
        t0 = cyc;
        push_exp(1'b1, 1'b0, 16'h8800, map_f(16'h8800));
        wait_obs(1, 20, ok);
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL reset_mid_timeout got=no_ready want=ready"); end
        pop_pair(e, o, oc);
        n_cmp++;
        if (o !== e) begin n_bad++; $display("FAIL reset_mid_acc got=%h want=%h", o, e); end
        n_cmp++;
        if (oc - t0 + 1 != LAT + 2) begin n_bad++; $display("FAIL reset_mid_latency got=%0d want=%0d", oc - t0 + 1, LAT + 2); end
    endtask

    task automatic test_final();
        repeat (4) @(negedge clockgb);
        #1;
        n_cmp++;
        if (both_rdy != 0) begin n_bad++; $display("FAIL ready_exclusive got=%0d want=0", both_rdy); end
        n_cmp++;
        if (obs_q.size() != 0) begin n_bad++; $display("FAIL extra_ready got=%0d want=0", obs_q.size()); end
        n_cmp++;
        if (outs() !== {last_cpu_rd, last_dma_rd, 28'h0})
            begin n_bad++; $display("FAIL final_idle got=%h want=%h", outs(), {last_cpu_rd, last_dma_rd, 28'h0}); end
    endtask

    initial begin
        n_cmp = 0; n_bad = 0; both_rdy = 0; in_acc = 1'b0; dma_hold = 1'b0;
        bus.cpu_address = '0; bus.cpu_indata = '0; bus.cpu_load = 1'b0; bus.cpu_store = 1'b0;
        bus.dma_address = '0; bus.dma_load = 1'b0;
        test_reset();
        test_cpu_read();
        test_cpu_write();
        test_both_strobes();
        test_same_cycle();
        test_burst();
        test_back_to_back();
        test_drop_mid();
        test_reset_mid();
        test_final();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
